// File: rtl/rca_batch_acc.sv
// rca_batch_acc: batch accumulator wrapped around an N-bit ripple-carry adder.
// It sums LEN operands per batch and returns the result through a valid/ready handshake.
// Optional macro RCA_END_AROUND_CARRY_EN enables ones'-complement (end-around carry)
// summing, which adds a FOLD state.

module a_n_rca #(
    parameter int N = 4
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         c_in,
    output logic [N-1:0] sum,
    output logic         c_out
);
    logic [N:0] c;
    assign c[0] = c_in;
    for (genvar i = 0; i < N; i++) begin : g_fa
        assign sum[i]   = a[i] ^ b[i] ^ c[i];
        assign c[i+1]   = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
    assign c_out = c[N];
endmodule

module rca_batch_acc #(
    parameter int N   = 4,
    parameter int LEN = 4,
    parameter int CW  = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          clear,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [N-1:0]  in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [N-1:0]  out_sum,
    output logic [CW-1:0] out_carries,
    output logic          busy
);
    localparam int BW = (LEN > 1) ? $clog2(LEN) : 1;

`ifdef RCA_END_AROUND_CARRY_EN
    typedef enum logic [1:0] {IDLE = 2'd0, ACC = 2'd1, DONE = 2'd2, FOLD = 2'd3} state_t;
`else
    typedef enum logic [1:0] {IDLE = 2'd0, ACC = 2'd1, DONE = 2'd2} state_t;
`endif

    state_t        state, state_d;
    logic [N-1:0]  acc;
    logic [BW-1:0] beat;
    logic [CW-1:0] carry_cnt;
    logic [N-1:0]  add_b, add_sum;
    logic          add_cin, add_cout;
    logic          xfer, last, restart;

    assign in_ready    = state == ACC;
    assign out_valid   = state == DONE;
    assign busy        = state != IDLE;
    assign out_sum     = acc;
    assign out_carries = carry_cnt;
    assign xfer        = in_valid & in_ready;
    assign last        = beat == BW'(LEN - 1);
    assign restart     = clear | (state == IDLE & start);

`ifdef RCA_END_AROUND_CARRY_EN
    logic cpend;
    logic fold;
    assign fold    = state == FOLD;
    assign add_b   = fold ? '0 : in_data;
    assign add_cin = cpend;
`else
    assign add_b   = in_data;
    assign add_cin = 1'b0;
`endif

    a_n_rca #(.N(N)) u_rca (
        .a     (acc),
        .b     (add_b),
        .c_in  (add_cin),
        .sum   (add_sum),
        .c_out (add_cout)
    );

    // Next-state decode; clear overrides every other condition
    always_comb begin
        state_d = state;
        if (clear)
            state_d = IDLE;
        else
            case (state)
                IDLE:    state_d = start ? ACC : IDLE;
`ifdef RCA_END_AROUND_CARRY_EN
                ACC:     state_d = (xfer && last) ? FOLD : ACC;
                FOLD:    state_d = DONE;
`else
                ACC:     state_d = (xfer && last) ? DONE : ACC;
`endif
                DONE:    state_d = out_ready ? IDLE : DONE;
                default: state_d = IDLE;
            endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_d;

    // Accumulator, beat counter and carry counter; cleared on start or clear
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            acc       <= '0;
            beat      <= '0;
            carry_cnt <= '0;
        end else if (restart) begin
            acc       <= '0;
            beat      <= '0;
            carry_cnt <= '0;
        end else if (xfer) begin
            acc       <= add_sum;
            beat      <= beat + BW'(1);
            carry_cnt <= carry_cnt + CW'(add_cout);
`ifdef RCA_END_AROUND_CARRY_EN
        end else if (fold) begin
            acc       <= add_sum;
            carry_cnt <= carry_cnt + CW'(add_cout);
`endif
        end

`ifdef RCA_END_AROUND_CARRY_EN
    // Pending end-around carry fed back into the next addition
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n)
            cpend <= 1'b0;
        else if (restart)
            cpend <= 1'b0;
        else if (xfer)
            cpend <= add_cout;
        else if (fold)
            cpend <= 1'b0;
`endif
endmodule

// File: doc/rca_batch_acc.md
Name: rca_batch_acc

Overview:
Sequential accumulator that sits directly upstream and downstream of an a_n_rca instance. It holds the adder's a operand in an accumulator register and streams incoming operands into b. It registers sum/c_out back into the accumulator and presents the batch result through a valid/ready handshake. It turns the combinational N-bit ripple-carry adder into a batch summing stage for the datapath.

Parameters:
N, 4, operand/accumulator width; passed to the internal a_n_rca #(N).
LEN, 4, operands per batch (>=1).
CW, 3, carry-counter width; must satisfy 2^CW-1 >= LEN.

Ports:
clk  input  1  single system clock, rising edge.
rst_n  input  1  asynchronous, active-low reset.
start  input  1  begin batch; sampled in IDLE only.
clear  input  1  synchronous abort; forces IDLE, zeroes state.
in_valid  input  1  operand valid.
in_ready  output  1  block accepts operand this cycle.
in_data  input  N  operand.
out_valid  output  1  batch result valid.
out_ready  input  1  consumer accepts result.
out_sum  output  N  accumulated sum mod 2^N.
out_carries  output  CW  count of adder c_out=1 events in batch.
busy  output  1  state != IDLE.

Behaviour:
- Reset (rst_n=0, async): state=IDLE, acc=0, beat=0, carry_cnt=0, out_valid=0, in_ready=0, busy=0; out_sum=0, out_carries=0.
- Adder hookup: a=acc, b=in_data (in FOLD state b=0), c_in=0 (see Optional Feature).
- States: IDLE, ACC, FOLD (macro-only), DONE.
- IDLE: in_ready=0. start=1 -> ACC next cycle; acc, beat, carry_cnt cleared on that edge.
- ACC: in_ready=1 combinationally (state-decoded only). Transfer = in_valid & in_ready. On transfer: acc<=sum, carry_cnt<=carry_cnt+c_out, beat<=beat+1. Transfer with beat==LEN-1 -> DONE (or FOLD with macro). No transfer -> hold everything.
- DONE: out_valid=1, out_sum=acc, out_carries=carry_cnt, in_ready=0. out_valid & out_ready -> IDLE next cycle. out_sum/out_carries hold their values while out_ready=0 (stable under backpressure). Outputs keep the last values in IDLE until the next start.
- Latency: result valid exactly 1 cycle after the LEN-th transfer (2 cycles with macro).
- Back-to-back batches: start is ignored outside IDLE. The earliest new start is sampled the cycle after the DONE handshake.
- clear: has priority over start, transfers, and the handshake. Next edge: IDLE, acc/beat/carry_cnt=0, out_valid=0. Any partial batch is discarded.
- carry_cnt cannot overflow given the CW constraint; no saturation logic.
- Width: all arithmetic is mod 2^N; the only carry information kept is carry_cnt.

Optional Feature:
Macro RCA_END_AROUND_CARRY_EN.
- Defined: ones'-complement (end-around) mode. A register cpend (reset 0, cleared with acc) drives c_in. Each transfer sets cpend<=c_out.
- After the LEN-th transfer, go to FOLD for one cycle: b=0, c_in=cpend, acc<=sum, carry_cnt+=c_out, cpend<=0. FOLD -> DONE.
- Result is the ones'-complement sum.
- Not defined: c_in tied 0, no cpend register, FOLD state absent.

Test Plan:
- Basic (N=4, LEN=4): start, operands 1,2,3,4 with in_valid held -> out_valid 1 cycle after 4th transfer, out_sum=0xA, out_carries=0.
- Carries: operands F,F,F,F -> out_sum=0xC, out_carries=3. With RCA_END_AROUND_CARRY_EN: out_sum=0xF, out_carries=3, out_valid 2 cycles after 4th transfer.
- Bubbles/backpressure: in_valid toggling 1,0,1,0..., then out_ready=0 for 5 cycles in DONE:
  - Only valid cycles count.
  - in_ready=0 throughout DONE.
  - out_sum stable.
  - Handshake on out_ready=1 -> IDLE.
- Clear mid-batch: clear after 2 transfers -> IDLE next cycle, out_valid=0. New batch 0,0,0,1 -> out_sum=0x1, out_carries=0.
- Async reset mid-batch: drop rst_n between clock edges -> outputs zero immediately. start ignored while rst_n=0, normal batch after release.
- start outside IDLE and start+clear in the same cycle -> no effect / clear wins (state IDLE).
